// File: rtl/mccp_pkg.sv
// Shared widths, opcode/flag/field codes and the condition evaluator for the
// MCCP decode/ALU front end.
package mccp_pkg;

    localparam int WIDTH       = 32;
    localparam int REGS_CODING = 3;
    localparam int FLAGS       = 4;
    localparam int OPCODE      = 4;
    localparam int MOV_CODE    = 3;
    localparam int CORE_NUM    = 2;
    localparam int INT_NUM     = 3;

    localparam int ZF = 3;
    localparam int OF = 2;
    localparam int SF = 1;
    localparam int CF = 0;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_SAR = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;
    localparam logic [3:0] OP_TST = 4'd13;
    localparam logic [3:0] OP_INC = 4'd14;
    localparam logic [3:0] OP_DEC = 4'd15;

    localparam logic [1:0] TYPE_ALU = 2'b00;
    localparam logic [1:0] TYPE_MOV = 2'b01;
    localparam logic [1:0] TYPE_MEM = 2'b10;
    localparam logic [1:0] TYPE_SYS = 2'b11;

    localparam logic [2:0] MOV_REG      = 3'b000;
    localparam logic [2:0] MOV_L        = 3'b001;
    localparam logic [2:0] MOV_H        = 3'b010;
    localparam logic [2:0] MOV_F        = 3'b011;
    localparam logic [2:0] MOV_SUB_CORE = 3'b100;
    localparam logic [2:0] MOV_JUMP     = 3'b111;

    localparam logic [2:0] COND_AL  = 3'b000;
    localparam logic [2:0] COND_Z   = 3'b001;
    localparam logic [2:0] COND_NZ  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_C   = 3'b101;
    localparam logic [2:0] COND_NC  = 3'b110;
    localparam logic [2:0] COND_GT  = 3'b111;

    localparam logic [1:0] SP_MY_STACK_BEGIN = 2'b00;
    localparam logic [1:0] SP_MY_STACK_END   = 2'b01;
    localparam logic [1:0] SP_STACK_BEGIN    = 2'b10;
    localparam logic [1:0] SP_EXC_ADDR       = 2'b11;

    typedef struct packed {
        logic                   alu_en;
        logic                   mem_en;
        logic                   wren;
        logic                   move_en;
        logic                   suffix;
        logic                   interrupt;
        logic                   write_stack_params;
        logic [OPCODE-1:0]      alu_opcode;
        logic [MOV_CODE-1:0]    mov_type;
        logic [WIDTH/2-1:0]     immediate;
        logic [REGS_CODING-1:0] op1;
        logic [REGS_CODING-1:0] op2;
        logic [INT_NUM-1:0]     int_num;
        logic [1:0]             stack_param_coding;
        logic [REGS_CODING-1:0] stack_param_reg;
    } dec_t;

    function automatic logic eval_cond(input logic [2:0] cond, input logic [FLAGS-1:0] f);
        logic res;
        case (cond)
            COND_AL: res = 1'b1;
            COND_Z:  res = f[ZF];
            COND_NZ: res = ~f[ZF];
            COND_LT: res = f[SF] ^ f[OF];
            COND_GE: res = ~(f[SF] ^ f[OF]);
            COND_C:  res = f[CF];
            COND_NC: res = ~f[CF];
            COND_GT: res = ~f[ZF] & ~(f[SF] ^ f[OF]);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mccp_alu.sv
// 32-bit MCCP ALU with registered result, flags and destination code.
// Multiplier present only when MCCP_MUL_EN is defined.
module mccp_alu
    import mccp_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   exec_en,
    input  logic [OPCODE-1:0]      opcode,
    input  logic [REGS_CODING-1:0] op1_code,
    input  logic [WIDTH-1:0]       op1_val,
    input  logic [WIDTH-1:0]       op2_val,
    input  logic                   cin,
    output logic [WIDTH-1:0]       alu_result,
    output logic [FLAGS-1:0]       alu_flags,
    output logic [REGS_CODING-1:0] alu_dest
);

    function automatic logic add_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
        return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    logic [WIDTH-1:0] res_s;
    logic [WIDTH-1:0] val_s;
    logic [WIDTH:0]   ext_s;
    logic             cf_s;
    logic             of_s;
    logic             upd_s;
    logic [FLAGS-1:0] flags_s;
    logic [4:0]       amt_s;
`ifdef MCCP_MUL_EN
    logic [2*WIDTH-1:0] prod_s;
`endif

    // Operation select; val_s is the value ZF/SF are derived from.
    always_comb begin
        res_s = op1_val;
        val_s = op1_val;
        ext_s = {(WIDTH+1){1'b0}};
        cf_s  = 1'b0;
        of_s  = 1'b0;
        upd_s = 1'b1;
        amt_s = op2_val[4:0];
`ifdef MCCP_MUL_EN
        prod_s = {(2*WIDTH){1'b0}};
`endif
        case (opcode)
            OP_ADD, OP_ADC: begin
                ext_s = {1'b0, op1_val} + {1'b0, op2_val}
                        + {{WIDTH{1'b0}}, (opcode == OP_ADC) ? cin : 1'b0};
                res_s = ext_s[WIDTH-1:0];
                val_s = res_s;
                cf_s  = ext_s[WIDTH];
                of_s  = add_ovf(op1_val, op2_val, res_s);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                ext_s = {1'b0, op1_val} - {1'b0, op2_val}
                        - {{WIDTH{1'b0}}, (opcode == OP_SBB) ? cin : 1'b0};
                val_s = ext_s[WIDTH-1:0];
                res_s = (opcode == OP_CMP) ? op1_val : val_s;
                cf_s  = ext_s[WIDTH];
                of_s  = sub_ovf(op1_val, op2_val, val_s);
            end
            OP_INC: begin
                ext_s = {1'b0, op1_val} + 33'd1;
                res_s = ext_s[WIDTH-1:0];
                val_s = res_s;
                cf_s  = ext_s[WIDTH];
                of_s  = add_ovf(op1_val, 32'd1, res_s);
            end
            OP_DEC: begin
                ext_s = {1'b0, op1_val} - 33'd1;
                res_s = ext_s[WIDTH-1:0];
                val_s = res_s;
                cf_s  = ext_s[WIDTH];
                of_s  = sub_ovf(op1_val, 32'd1, res_s);
            end
            OP_MUL: begin
`ifdef MCCP_MUL_EN
                prod_s = {{WIDTH{1'b0}}, op1_val} * {{WIDTH{1'b0}}, op2_val};
                res_s  = prod_s[WIDTH-1:0];
                val_s  = res_s;
                cf_s   = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                of_s   = cf_s;
`else
                res_s  = op1_val;
                upd_s  = 1'b0;
`endif
            end
            OP_AND, OP_TST: begin
                val_s = op1_val & op2_val;
                res_s = (opcode == OP_TST) ? op1_val : val_s;
            end
            OP_OR: begin
                res_s = op1_val | op2_val;
                val_s = res_s;
            end
            OP_XOR: begin
                res_s = op1_val ^ op2_val;
                val_s = res_s;
            end
            OP_NOT: begin
                res_s = ~op1_val;
                val_s = res_s;
            end
            // Widened by one bit so the last shifted-out bit lands in a fixed
            // position; with amount 0 that position is a constant 0.
            OP_SHL: begin
                ext_s = {1'b0, op1_val} << amt_s;
                res_s = ext_s[WIDTH-1:0];
                val_s = res_s;
                cf_s  = ext_s[WIDTH];
            end
            OP_SHR: begin
                ext_s = {op1_val, 1'b0} >> amt_s;
                res_s = ext_s[WIDTH:1];
                val_s = res_s;
                cf_s  = ext_s[0];
            end
            OP_SAR: begin
                ext_s = $signed({op1_val, 1'b0}) >>> amt_s;
                res_s = ext_s[WIDTH:1];
                val_s = res_s;
                cf_s  = ext_s[0];
            end
            default: begin
                res_s = op1_val;
                val_s = op1_val;
            end
        endcase
        flags_s     = {FLAGS{1'b0}};
        flags_s[ZF] = (val_s == {WIDTH{1'b0}});
        flags_s[SF] = val_s[WIDTH-1];
        flags_s[CF] = cf_s;
        flags_s[OF] = of_s;
    end

    // Result/flags/destination registers, loaded on the execute strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_result <= {WIDTH{1'b0}};
            alu_flags  <= {FLAGS{1'b0}};
            alu_dest   <= {REGS_CODING{1'b0}};
        end else if (exec_en) begin
            alu_result <= res_s;
            alu_dest   <= op1_code;
            if (upd_s) begin
                alu_flags <= flags_s;
            end
        end
    end

endmodule

// File: rtl/mccp_decode_alu.sv
// MCCP core decode/execute front end: instruction decode plus the ALU.
// Optional build macro MCCP_MUL_EN enables the ALU multiplier.
module mccp_decode_alu
    import mccp_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dec_en,
    input  logic [WIDTH-1:0]       instruction,
    input  logic                   instr_choose,
    input  logic [FLAGS-1:0]       flags_in,
    input  logic [CORE_NUM-1:0]    core_index,
    input  logic                   alu_exec_en,
    input  logic [WIDTH-1:0]       op1_val,
    input  logic [WIDTH-1:0]       op2_val,
    input  logic                   cin,
    output logic                   alu_en,
    output logic                   mem_en,
    output logic                   wren,
    output logic                   move_en,
    output logic                   suffix,
    output logic                   interrupt,
    output logic                   write_stack_params,
    output logic [OPCODE-1:0]      alu_opcode,
    output logic [MOV_CODE-1:0]    mov_type,
    output logic [WIDTH/2-1:0]     immediate,
    output logic [REGS_CODING-1:0] op1,
    output logic [REGS_CODING-1:0] op2,
    output logic [INT_NUM-1:0]     int_num,
    output logic [1:0]             stack_param_coding,
    output logic [REGS_CODING-1:0] stack_param_reg,
    output logic [WIDTH-1:0]       alu_result,
    output logic [FLAGS-1:0]       alu_flags,
    output logic [REGS_CODING-1:0] alu_dest
);

    dec_t        dec_s;
    dec_t        dec_r;
    logic [14:0] half_s;

    // Decode of the long word or the selected short half (its bit 15 is dropped).
    always_comb begin
        dec_s  = '0;
        half_s = instr_choose ? instruction[14:0] : instruction[30:16];
        if (instruction[WIDTH-1]) begin
            dec_s.suffix = eval_cond(instruction[30:28], flags_in);
            case (instruction[27:26])
                2'b00: begin
                    dec_s.move_en   = 1'b1;
                    dec_s.mov_type  = MOV_L;
                    dec_s.op1       = instruction[21:19];
                    dec_s.immediate = instruction[15:0];
                end
                2'b01: begin
                    dec_s.move_en   = 1'b1;
                    dec_s.mov_type  = MOV_H;
                    dec_s.op1       = instruction[21:19];
                    dec_s.immediate = instruction[15:0];
                end
                default: begin
                    dec_s.move_en = 1'b0;
                end
            endcase
        end else begin
            dec_s.suffix = eval_cond(half_s[14:12], flags_in);
            case (half_s[11:10])
                TYPE_ALU: begin
                    dec_s.alu_en     = 1'b1;
                    dec_s.alu_opcode = half_s[9:6];
                    dec_s.op1        = half_s[5:3];
                    dec_s.op2        = half_s[2:0];
                end
                TYPE_MOV: begin
                    case (half_s[9:7])
                        MOV_REG, MOV_F, MOV_JUMP: begin
                            dec_s.move_en  = 1'b1;
                            dec_s.mov_type = half_s[9:7];
                            dec_s.op1      = half_s[5:3];
                            dec_s.op2      = half_s[2:0];
                        end
                        MOV_SUB_CORE: begin
                            dec_s.move_en   = 1'b1;
                            dec_s.mov_type  = MOV_L;
                            dec_s.op1       = half_s[5:3];
                            dec_s.op2       = half_s[2:0];
                            dec_s.immediate = {{(WIDTH/2-CORE_NUM){1'b0}}, core_index};
                        end
                        default: begin
                            dec_s.move_en = 1'b0;
                        end
                    endcase
                end
                TYPE_MEM: begin
                    dec_s.mem_en = 1'b1;
                    dec_s.wren   = half_s[9];
                    dec_s.op1    = half_s[5:3];
                    dec_s.op2    = half_s[2:0];
                end
                default: begin
                    if (half_s[9]) begin
                        dec_s.write_stack_params = 1'b1;
                        dec_s.stack_param_coding = half_s[8:7];
                        dec_s.stack_param_reg    = half_s[2:0];
                    end else begin
                        dec_s.interrupt = 1'b1;
                        dec_s.int_num   = half_s[8:6];
                    end
                end
            endcase
        end
    end

    // Decoded-field register, loaded on the decode strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_r <= '0;
        end else if (dec_en) begin
            dec_r <= dec_s;
        end
    end

    assign alu_en             = dec_r.alu_en;
    assign mem_en             = dec_r.mem_en;
    assign wren               = dec_r.wren;
    assign move_en            = dec_r.move_en;
    assign suffix             = dec_r.suffix;
    assign interrupt          = dec_r.interrupt;
    assign write_stack_params = dec_r.write_stack_params;
    assign alu_opcode         = dec_r.alu_opcode;
    assign mov_type           = dec_r.mov_type;
    assign immediate          = dec_r.immediate;
    assign op1                = dec_r.op1;
    assign op2                = dec_r.op2;
    assign int_num            = dec_r.int_num;
    assign stack_param_coding = dec_r.stack_param_coding;
    assign stack_param_reg    = dec_r.stack_param_reg;

    // The ALU sees the registered opcode, so a same-edge decode does not affect it.
    mccp_alu u_alu (
        .clk        (clk),
        .reset      (reset),
        .exec_en    (alu_exec_en),
        .opcode     (dec_r.alu_opcode),
        .op1_code   (dec_r.op1),
        .op1_val    (op1_val),
        .op2_val    (op2_val),
        .cin        (cin),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .alu_dest   (alu_dest)
    );

endmodule

// File: tb/tb_mccp_decode_alu.sv
// Directed, table-driven bench for mccp_decode_alu (decoder and ALU).
module tb_mccp_decode_alu;
    import mccp_pkg::*;

    logic        clk = 1'b0;
    logic        reset, dec_en, instr_choose, alu_exec_en, cin;
    logic [31:0] instruction, op1_val, op2_val;
    logic [3:0]  flags_in;
    logic [1:0]  core_index;
    logic        alu_en, mem_en, wren, move_en, suffix, interrupt, write_stack_params;
    logic [3:0]  alu_opcode, alu_flags;
    logic [2:0]  mov_type, op1, op2, int_num, stack_param_reg, alu_dest;
    logic [15:0] immediate;
    logic [1:0]  stack_param_coding;
    logic [31:0] alu_result;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mccp_decode_alu dut (
        .clk(clk), .reset(reset), .dec_en(dec_en), .instruction(instruction),
        .instr_choose(instr_choose), .flags_in(flags_in), .core_index(core_index),
        .alu_exec_en(alu_exec_en), .op1_val(op1_val), .op2_val(op2_val), .cin(cin),
        .alu_en(alu_en), .mem_en(mem_en), .wren(wren), .move_en(move_en),
        .suffix(suffix), .interrupt(interrupt), .write_stack_params(write_stack_params),
        .alu_opcode(alu_opcode), .mov_type(mov_type), .immediate(immediate),
        .op1(op1), .op2(op2), .int_num(int_num), .stack_param_coding(stack_param_coding),
        .stack_param_reg(stack_param_reg), .alu_result(alu_result),
        .alu_flags(alu_flags), .alu_dest(alu_dest)
    );

    typedef struct {
        logic [31:0] instr;
        logic        ch;
        logic [3:0]  fl;
        logic [1:0]  core;
        dec_t        exp;
    } dvec_t;

    typedef struct {
        logic [3:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] res;
        logic [3:0]  fl;
    } avec_t;

    function automatic dec_t mk(logic a, logic m, logic w, logic mv, logic s, logic i, logic ws,
                                logic [3:0] opc, logic [2:0] mt, logic [15:0] imm,
                                logic [2:0] o1, logic [2:0] o2, logic [2:0] inum,
                                logic [1:0] sc, logic [2:0] sr);
        dec_t d;
        d.alu_en = a; d.mem_en = m; d.wren = w; d.move_en = mv; d.suffix = s;
        d.interrupt = i; d.write_stack_params = ws; d.alu_opcode = opc; d.mov_type = mt;
        d.immediate = imm; d.op1 = o1; d.op2 = o2; d.int_num = inum;
        d.stack_param_coding = sc; d.stack_param_reg = sr;
        return d;
    endfunction

    function automatic dec_t dut_dec();
        return {alu_en, mem_en, wren, move_en, suffix, interrupt, write_stack_params,
                alu_opcode, mov_type, immediate, op1, op2, int_num,
                stack_param_coding, stack_param_reg};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic decode(input logic [31:0] ins, input logic ch, input logic [3:0] fl,
                          input logic [1:0] core);
        @(negedge clk);
        instruction = ins; instr_choose = ch; flags_in = fl; core_index = core; dec_en = 1'b1;
        @(posedge clk); #1;
        dec_en = 1'b0;
    endtask

    task automatic execute(input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        op1_val = a; op2_val = b; cin = c; alu_exec_en = 1'b1;
        @(posedge clk); #1;
        alu_exec_en = 1'b0;
    endtask

    dvec_t dv[16];
    avec_t av[19];

    initial begin
        reset = 1'b1; dec_en = 1'b0; alu_exec_en = 1'b0; instruction = 32'h0;
        instr_choose = 1'b0; flags_in = 4'h0; core_index = 2'd0;
        op1_val = 32'h0; op2_val = 32'h0; cin = 1'b0;

        dv[0]  = '{32'h0047_0000, 1'b0, 4'b0000, 2'd0, mk(1,0,0,0,1,0,0,4'd1,3'd0,16'h0,3'd0,3'd7,3'd0,2'd0,3'd0)};
        dv[1]  = '{32'h8008_1234, 1'b0, 4'b0000, 2'd0, mk(0,0,0,1,1,0,0,4'd0,3'd1,16'h1234,3'd1,3'd0,3'd0,2'd0,3'd0)};
        dv[2]  = '{32'h8008_1234, 1'b1, 4'b0000, 2'd0, mk(0,0,0,1,1,0,0,4'd0,3'd1,16'h1234,3'd1,3'd0,3'd0,2'd0,3'd0)};
        dv[3]  = '{32'h1000_0000, 1'b0, 4'b0000, 2'd0, mk(1,0,0,0,0,0,0,4'd0,3'd0,16'h0,3'd0,3'd0,3'd0,2'd0,3'd0)};
        dv[4]  = '{32'h1000_0000, 1'b0, 4'b1000, 2'd0, mk(1,0,0,0,1,0,0,4'd0,3'd0,16'h0,3'd0,3'd0,3'd0,2'd0,3'd0)};
        dv[5]  = '{32'h7FFF_0600, 1'b1, 4'b0000, 2'd2, mk(0,0,0,1,1,0,0,4'd0,3'd1,16'h0002,3'd0,3'd0,3'd0,2'd0,3'd0)};
        dv[6]  = '{32'h0D40_0000, 1'b0, 4'b0000, 2'd0, mk(0,0,0,0,1,1,0,4'd0,3'd0,16'h0,3'd0,3'd0,3'd5,2'd0,3'd0)};
        dv[7]  = '{32'h0F05_0000, 1'b0, 4'b0000, 2'd0, mk(0,0,0,0,1,0,1,4'd0,3'd0,16'h0,3'd0,3'd0,3'd0,2'd2,3'd5)};
        dv[8]  = '{32'h0A1C_0000, 1'b0, 4'b0000, 2'd0, mk(0,1,1,0,1,0,0,4'd0,3'd0,16'h0,3'd3,3'd4,3'd0,2'd0,3'd0)};
        dv[9]  = '{32'h0000_8791, 1'b1, 4'b0000, 2'd0, mk(0,0,0,1,1,0,0,4'd0,3'd7,16'h0,3'd2,3'd1,3'd0,2'd0,3'd0)};
        dv[10] = '{32'h0480_0000, 1'b0, 4'b0000, 2'd0, mk(0,0,0,0,1,0,0,4'd0,3'd0,16'h0,3'd0,3'd0,3'd0,2'd0,3'd0)};
        dv[11] = '{32'h8808_1234, 1'b0, 4'b0000, 2'd0, mk(0,0,0,0,1,0,0,4'd0,3'd0,16'h0,3'd0,3'd0,3'd0,2'd0,3'd0)};
        dv[12] = '{32'hD408_ABCD, 1'b0, 4'b0001, 2'd0, mk(0,0,0,1,1,0,0,4'd0,3'd2,16'hABCD,3'd1,3'd0,3'd0,2'd0,3'd0)};
        dv[13] = '{32'h7000_0000, 1'b0, 4'b1000, 2'd0, mk(1,0,0,0,0,0,0,4'd0,3'd0,16'h0,3'd0,3'd0,3'd0,2'd0,3'd0)};
        dv[14] = '{32'h3000_0000, 1'b0, 4'b0010, 2'd0, mk(1,0,0,0,1,0,0,4'd0,3'd0,16'h0,3'd0,3'd0,3'd0,2'd0,3'd0)};
        dv[15] = '{32'h7000_0000, 1'b0, 4'b0000, 2'd0, mk(1,0,0,0,1,0,0,4'd0,3'd0,16'h0,3'd0,3'd0,3'd0,2'd0,3'd0)};

        // {opcode, op1, op2, cin, result, flags ZOSC}
        av[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,        1'b0, 32'h0,         4'b1001};
        av[1]  = '{OP_SUB, 32'h8000_0000, 32'h1,        1'b0, 32'h7FFF_FFFF, 4'b0100};
        av[2]  = '{OP_ADC, 32'h1,         32'h2,        1'b1, 32'h4,         4'b0000};
        av[3]  = '{OP_SBB, 32'h0,         32'h0,        1'b1, 32'hFFFF_FFFF, 4'b0011};
        av[4]  = '{OP_AND, 32'hF0F0,      32'h0FF0,     1'b0, 32'h00F0,      4'b0000};
        av[5]  = '{OP_XOR, 32'h5,         32'h5,        1'b0, 32'h0,         4'b1000};
        av[6]  = '{OP_NOT, 32'h0,         32'h1234,     1'b0, 32'hFFFF_FFFF, 4'b0010};
        av[7]  = '{OP_SHL, 32'h8000_0001, 32'h1,        1'b0, 32'h2,         4'b0001};
        av[8]  = '{OP_SHR, 32'h3,         32'h1,        1'b0, 32'h1,         4'b0001};
        av[9]  = '{OP_SAR, 32'h8000_0000, 32'h4,        1'b0, 32'hF800_0000, 4'b0010};
        av[10] = '{OP_SHL, 32'h8000_0000, 32'h0,        1'b0, 32'h8000_0000, 4'b0010};
        av[11] = '{OP_CMP, 32'h5,         32'h5,        1'b0, 32'h5,         4'b1000};
        av[12] = '{OP_TST, 32'h1,         32'h2,        1'b0, 32'h1,         4'b1000};
        av[13] = '{OP_INC, 32'h7FFF_FFFF, 32'h0,        1'b0, 32'h8000_0000, 4'b0110};
        av[14] = '{OP_DEC, 32'h0,         32'h0,        1'b0, 32'hFFFF_FFFF, 4'b0011};
        av[15] = '{OP_OR,  32'h0,         32'h0,        1'b0, 32'h0,         4'b1000};
`ifdef MCCP_MUL_EN
        av[16] = '{OP_MUL, 32'h1_0000,    32'h1_0000,   1'b0, 32'h0,         4'b1101};
`else
        av[16] = '{OP_MUL, 32'h1_0000,    32'h1_0000,   1'b0, 32'h1_0000,    4'b1000};
`endif
        av[17] = '{OP_ADD, 32'h1,         32'h1,        1'b1, 32'h2,         4'b0000};
        av[18] = '{OP_SUB, 32'h1,         32'h2,        1'b0, 32'hFFFF_FFFF, 4'b0011};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_dec", 64'(dut_dec()), 64'h0);
        chk("reset_alu", {alu_result, 25'h0, alu_flags, alu_dest}, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            decode(dv[i].instr, dv[i].ch, dv[i].fl, dv[i].core);
            chk($sformatf("dec%0d", i), 64'(dut_dec()), 64'(dv[i].exp));
        end

        // Outputs hold while dec_en is low.
        @(negedge clk);
        instruction = 32'h0A1C_0000; flags_in = 4'b0000;
        @(posedge clk); #1;
        chk("dec_hold", 64'(dut_dec()), 64'(dv[15].exp));

        for (int i = 0; i < 19; i++) begin
            logic [2:0] oc;
            oc = 3'(i);
            decode({1'b0, 3'b000, 2'b00, av[i].opc, oc, 3'b000, 16'h0}, 1'b0, 4'h0, 2'd0);
            execute(av[i].a, av[i].b, av[i].c);
            chk($sformatf("alu%0d_res", i), 64'(alu_result), 64'(av[i].res));
            chk($sformatf("alu%0d_flags", i), 64'(alu_flags), 64'(av[i].fl));
            chk($sformatf("alu%0d_dest", i), 64'(alu_dest), 64'(oc));
        end

        // ALU holds while alu_exec_en is low.
        @(negedge clk);
        op1_val = 32'h55; op2_val = 32'h66;
        @(posedge clk); #1;
        chk("alu_hold", 64'(alu_result), 64'(av[18].res));

        // Same-edge decode and execute: the ALU uses the previous (add, op1=2).
        decode(32'h0010_0000, 1'b0, 4'h0, 2'd0);
        @(negedge clk);
        instruction = 32'h00A8_0000; dec_en = 1'b1;
        op1_val = 32'd10; op2_val = 32'd3; cin = 1'b0; alu_exec_en = 1'b1;
        @(posedge clk); #1;
        dec_en = 1'b0;
        chk("both_res", 64'(alu_result), 64'd13);
        chk("both_dest", 64'(alu_dest), 64'd2);
        chk("both_opc", 64'(alu_opcode), 64'(OP_SUB));
        execute(32'd10, 32'd3, 1'b0);
        chk("after_res", 64'(alu_result), 64'd7);
        chk("after_dest", 64'(alu_dest), 64'd5);

        // Reset mid-stream beats both strobes.
        @(negedge clk);
        reset = 1'b1; dec_en = 1'b1; alu_exec_en = 1'b1; instruction = 32'h0047_0000;
        @(posedge clk); #1;
        chk("mid_reset_dec", 64'(dut_dec()), 64'h0);
        chk("mid_reset_alu", {alu_result, 25'h0, alu_flags, alu_dest}, 64'h0);
        @(negedge clk);
        reset = 1'b0; dec_en = 1'b0; alu_exec_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
